imem_load_ctrl: RTL and testbench
=================================

Name: imem_load_ctrl

Overview:
- Owns the single port of the instruction memory (program ROM/RAM, 16K x 32, word-addressed) and arbitrates it between the CPU fetch path and a UART program loader.
- In RUN mode the memory address follows the CPU fetch address.
- In LOAD mode the CPU is held, received bytes are packed little-endian into 32-bit words, and the words are written at consecutive addresses from 0.
- Sits between the fetch unit, the UART receiver and the instruction memory.

Parameters:
ADDR_W, 14, word-address width of instruction memory
DEPTH, 16384, number of words; loader stops after writing word DEPTH-1
RELEASE_CYCLES, 4, cycles cpu_hold stays high after last write before returning to RUN

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  reset, asynchronous, active-high
load_req  input  1  level request for programming mode; already synchronised
rx_valid  input  1  one-cycle strobe, new UART byte on rx_data
rx_data  input  8  received byte
fetch_addr  input  ADDR_W  CPU word address (PC[15:2])
fetch_data  output  32  instruction to CPU, equal to mem_rdata
mem_addr  output  ADDR_W  instruction memory address
mem_wdata  output  32  write data
mem_we  output  1  write enable, one-cycle pulse per word
mem_rdata  input  32  memory read data (synchronous read)
cpu_hold  output  1  high holds CPU PC in reset/stall
load_done  output  1  one-cycle pulse when a load completes
word_count  output  ADDR_W+1  words written in current/last load
load_csum  output  32  see Optional Feature

Behaviour:
- Reset (async): state=RUN, cpu_hold=0, mem_we=0, load_done=0, word_count=0, byte_cnt=0, shift reg=0, load_csum=0.
- States: RUN, LOAD, WRITE, RELEASE.
- RUN: mem_addr=fetch_addr (combinational), mem_we=0, cpu_hold=0. If load_req=1: go to LOAD, clear word_ptr, word_count, byte_cnt, shift reg. cpu_hold rises the cycle after load_req is sampled.
- LOAD: cpu_hold=1, mem_addr=word_ptr.
  - On rx_valid, rx_data goes to bits [8*byte_cnt+7 : 8*byte_cnt] (first byte is [7:0]) and byte_cnt increments.
  - When the 4th byte is accepted: go to WRITE.
  - If load_req=0 and rx_valid=0: with byte_cnt>0, go to WRITE with the unfilled bytes zero; with byte_cnt=0, go to RELEASE.
- WRITE (exactly 1 cycle): mem_we=1, mem_addr=word_ptr, mem_wdata=assembled word. word_ptr and word_count increment; byte_cnt and shift reg clear.
  - rx_valid during WRITE is accepted as byte 0 of the next word (no byte lost).
  - Next state is RELEASE if word_ptr was DEPTH-1 or load_req=0; otherwise LOAD.
  - Overflow: after DEPTH words, remaining bytes are ignored until RUN.
- RELEASE: cpu_hold=1, mem_addr=fetch_addr. Counts RELEASE_CYCLES cycles, then pulses load_done for 1 cycle on entry to RUN; cpu_hold drops in the same cycle.
  - RUN is not re-entered as LOAD while load_req is still high: load_req must be seen low in RUN before a new load is armed (edge-armed).
- word_count holds its value after the load until the next load starts.
- fetch_data always equals mem_rdata. There is no extra latency beyond the memory's 1-cycle read.
- Reset mid-load: immediate return to RUN with cpu_hold=0. Already-written words stay in memory; a partial word is discarded.

Optional Feature:
- Macro IMEM_LOAD_CSUM_EN.
- Defined: load_csum is the running XOR of every word written in the current load. It is cleared on load start and on reset, updated in the WRITE cycle, and held afterwards.
- Undefined: load_csum is tied to 32'h0 and no checksum register is built.

Test Plan:
- Reset, then fetch_addr=5 in RUN -> mem_addr=5, mem_we=0, cpu_hold=0, fetch_data=mem_rdata one cycle later.
- load_req=1, bytes 0x78,0x56,0x34,0x12,0xEF,0xBE,0xAD,0xDE, then load_req=0 -> two mem_we pulses: addr 0 data 32'h12345678, addr 1 data 32'hDEADBEEF. word_count=2; load_done pulses RELEASE_CYCLES+1 cycles after load_req drops; csum (macro on) = 32'hCC99E897.
- 6 bytes then load_req=0 -> word 1 written as 32'h0000BBAA (bytes 0xAA,0xBB), word_count=2.
- rx_valid asserted exactly in the WRITE cycle -> that byte appears in [7:0] of the next word.
- DEPTH=4 override, 20 bytes -> exactly 4 writes to addrs 0-3, extra bytes ignored, word_count=4, then RELEASE.
- Assert reset after 2 written words and 2 bytes -> cpu_hold=0 immediately, no further mem_we, word_count=0.

Source files
------------

// File: rtl/imem_load_ctrl.sv
// Instruction memory port owner: arbitrates the single memory port between the CPU
// fetch path (RUN) and a UART program loader (LOAD/WRITE/RELEASE).
// Optional build macro IMEM_LOAD_CSUM_EN adds a running XOR checksum of loaded words;
// without it load_csum is tied to zero and no checksum register exists.
module imem_load_ctrl #(
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned DEPTH          = 16384,
  parameter int unsigned RELEASE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       load_csum
);

  localparam int unsigned RelW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
  localparam logic [RelW-1:0]   RelLast = RelW'(RELEASE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StRun, StLoad, StWrite, StRelease} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   word_ptr_q;
  logic [ADDR_W:0]     word_count_q;
  logic [1:0]          byte_cnt_q;
  logic [23:0]         shift_q;     // bytes 0..2 of the word being assembled
  logic [31:0]         wdata_q;     // word presented during the WRITE cycle
  logic [RelW-1:0]     rel_cnt_q;
  logic                cpu_hold_q;
  logic                mem_we_q;
  logic                load_done_q;
  logic                armed_q;     // load_req has been seen low since the last load
  logic                load_start;

  assign load_start = (state_q == StRun) && load_req && armed_q;

  // Main load FSM with registered hold/write/done outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StRun;
      word_ptr_q   <= '0;
      word_count_q <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      wdata_q      <= '0;
      rel_cnt_q    <= '0;
      cpu_hold_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      load_done_q  <= 1'b0;
      armed_q      <= 1'b1;
    end else begin
      mem_we_q    <= 1'b0;
      load_done_q <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (!load_req) begin
            armed_q <= 1'b1;
          end
          if (load_start) begin
            state_q      <= StLoad;
            armed_q      <= 1'b0;
            cpu_hold_q   <= 1'b1;
            word_ptr_q   <= '0;
            word_count_q <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
          end
        end
        StLoad: begin
          if (rx_valid) begin
            if (byte_cnt_q == 2'd3) begin
              wdata_q    <= {rx_data, shift_q};
              shift_q    <= '0;
              byte_cnt_q <= '0;
              mem_we_q   <= 1'b1;
              state_q    <= StWrite;
            end else begin
              unique case (byte_cnt_q)
                2'd0:    shift_q[7:0]   <= rx_data;
                2'd1:    shift_q[15:8]  <= rx_data;
                default: shift_q[23:16] <= rx_data;
              endcase
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end else if (!load_req) begin
            if (byte_cnt_q != 2'd0) begin
              // Flush the partial word; unfilled upper bytes are already zero.
              wdata_q    <= {8'h00, shift_q};
              shift_q    <= '0;
              byte_cnt_q <= '0;
              mem_we_q   <= 1'b1;
              state_q    <= StWrite;
            end else begin
              rel_cnt_q <= '0;
              state_q   <= StRelease;
            end
          end
        end
        StWrite: begin
          word_ptr_q   <= word_ptr_q + ADDR_W'(1);
          word_count_q <= word_count_q + (ADDR_W + 1)'(1);
          if ((word_ptr_q == LastPtr) || !load_req) begin
            rel_cnt_q <= '0;
            state_q   <= StRelease;
          end else begin
            state_q <= StLoad;
            // A byte arriving during the write starts the next word.
            if (rx_valid) begin
              shift_q    <= {16'h0000, rx_data};
              byte_cnt_q <= 2'd1;
            end
          end
        end
        StRelease: begin
          if (rel_cnt_q == RelLast) begin
            state_q     <= StRun;
            cpu_hold_q  <= 1'b0;
            load_done_q <= 1'b1;
          end else begin
            rel_cnt_q <= rel_cnt_q + RelW'(1);
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

`ifdef IMEM_LOAD_CSUM_EN
  logic [31:0] csum_q;

  // Running XOR of every word written in the current load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= '0;
    end else if (load_start) begin
      csum_q <= '0;
    end else if (state_q == StWrite) begin
      csum_q <= csum_q ^ wdata_q;
    end
  end

  assign load_csum = csum_q;
`else
  assign load_csum = 32'h0;
`endif

  // Memory address follows the loader pointer only while loading or writing.
  always_comb begin
    mem_addr = fetch_addr;
    if ((state_q == StLoad) || (state_q == StWrite)) begin
      mem_addr = word_ptr_q;
    end
  end

  assign fetch_data = mem_rdata;
  assign mem_wdata  = wdata_q;
  assign mem_we     = mem_we_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: a byte-stream packing model feeds an
// expected-write scoreboard, plus directed literal checks of timing and boundaries.
module tb_imem_load_ctrl;

  localparam int unsigned AW = 14;
  localparam int unsigned RC = 4;

  logic          clk = 1'b0;
  logic          reset, load_req, rx_valid;
  logic [7:0]    rx_data;
  logic [AW-1:0] fetch_addr;

  logic [31:0]   fetch_data, mem_wdata, mem_rdata, load_csum;
  logic [AW-1:0] mem_addr;
  logic          mem_we, cpu_hold, load_done;
  logic [AW:0]   word_count;

  logic [31:0]   fetch_data4, mem_wdata4, load_csum4;
  logic [AW-1:0] mem_addr4;
  logic          mem_we4, cpu_hold4, load_done4;
  logic [AW:0]   word_count4;
  logic [31:0]   rdata4 = 32'h0;

  imem_load_ctrl u_dut (
    .clk(clk), .reset(reset), .load_req(load_req), .rx_valid(rx_valid), .rx_data(rx_data),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .word_count(word_count), .load_csum(load_csum)
  );

  imem_load_ctrl #(.ADDR_W(AW), .DEPTH(4), .RELEASE_CYCLES(RC)) u_dut4 (
    .clk(clk), .reset(reset), .load_req(load_req), .rx_valid(rx_valid), .rx_data(rx_data),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data4), .mem_addr(mem_addr4),
    .mem_wdata(mem_wdata4), .mem_we(mem_we4), .mem_rdata(rdata4), .cpu_hold(cpu_hold4),
    .load_done(load_done4), .word_count(word_count4), .load_csum(load_csum4)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory returning an address-derived pattern.
  always @(posedge clk) mem_rdata <= 32'hA5A5_0000 | {18'd0, mem_addr};

  int n_tests = 0;
  int n_fail  = 0;

  logic [45:0]   exp_q[$];
  logic [7:0]    stim[$];
  int            exp_count;
  logic [31:0]   exp_csum;
  logic [31:0]   wlog_data[$];
  logic [AW-1:0] wlog_addr[$];
  logic [31:0]   w4_data[$];
  logic [AW-1:0] w4_addr[$];
  int            d4_done_n;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Pack the stimulus bytes little-endian into words; optionally zero-pad a tail.
  task automatic model_build(input bit flush);
    int nw;
    logic [31:0] w;
    exp_count = 0;
    exp_csum  = 32'h0;
    nw = flush ? (stim.size() + 3) / 4 : stim.size() / 4;
    for (int i = 0; i < nw; i++) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) begin
        if (4 * i + k < stim.size()) w[8*k +: 8] = stim[4*i+k];
      end
      exp_q.push_back({i[AW-1:0], w});
      exp_count++;
`ifdef IMEM_LOAD_CSUM_EN
      exp_csum = exp_csum ^ w;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int gap);
    foreach (stim[i]) begin
      rx_valid = 1'b1;
      rx_data  = stim[i];
      tick();
      rx_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic wait_done(output int cyc);
    int k;
    cyc = 0;
    k   = 0;
    while (cyc == 0 && k < 60) begin
      @(posedge clk);
      #1;
      k++;
      if (load_done) cyc = k;
    end
    if (cyc == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL load_done_timeout: no pulse within %0d cycles", k);
    end
    #1;
  endtask

  // Scoreboard: checks main DUT outputs every cycle against the packing model.
  always @(negedge clk) begin
    if (!reset) begin
      check("fetch_data", fetch_data, mem_rdata);
      if (!cpu_hold) begin
        check("run_addr", mem_addr, fetch_addr);
        check("run_we", mem_we, 1'b0);
      end
      if (mem_we) begin
        wlog_addr.push_back(mem_addr);
        wlog_data.push_back(mem_wdata);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0h data %0h, none required", mem_addr,
                   mem_wdata);
        end else begin
          logic [45:0] e;
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e[45:32]);
          check("wr_data", mem_wdata, e[31:0]);
        end
      end
      if (load_done) begin
        check("done_count", word_count, exp_count);
        check("done_csum", load_csum, exp_csum);
      end
    end
  end

  // Record writes and completions of the DEPTH=4 instance.
  always @(negedge clk) begin
    if (!reset && mem_we4) begin
      w4_addr.push_back(mem_addr4);
      w4_data.push_back(mem_wdata4);
    end
    if (!reset && load_done4) d4_done_n++;
  end

  initial begin
    int cyc;
    reset = 1'b0; load_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h0; fetch_addr = '0;
    #2 reset = 1'b1;
    #1;
    check("rst_hold", cpu_hold, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_done", load_done, 1'b0);
    check("rst_count", word_count, 0);
    check("rst_csum", load_csum, 32'h0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Fetch path in RUN.
    fetch_addr = 14'd5;
    #1;
    check("fetch_mem_addr", mem_addr, 14'd5);
    check("fetch_we", mem_we, 1'b0);
    #1;
    tick();
    check("fetch_rdata", fetch_data, 32'hA5A5_0005);

    // Two full words.
    stim = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wlog_addr.delete(); wlog_data.delete();
    model_build(1'b1);
    load_req = 1'b1;
    #1 check("hold_before", cpu_hold, 1'b0);
    #1;
    tick();
    check("hold_rise", cpu_hold, 1'b1);
    send(1);
    load_req = 1'b0;
    wait_done(cyc);
    check("done_latency", cyc, RC + 1);
    check("t2_nwr", wlog_data.size(), 2);
    check("t2_addr1", wlog_addr[1], 14'd1);
    check("t2_w0", wlog_data[0], 32'h1234_5678);
    check("t2_w1", wlog_data[1], 32'hDEAD_BEEF);
    check("t2_count", word_count, 2);
`ifdef IMEM_LOAD_CSUM_EN
    check("t2_csum", load_csum, 32'hCC99_E897);
`else
    check("t2_csum", load_csum, 32'h0);
`endif
    repeat (3) tick();
    check("t2_count_held", word_count, 2);

    // Partial trailing word.
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
    wlog_addr.delete(); wlog_data.delete();
    model_build(1'b1);
    load_req = 1'b1;
    tick();
    send(1);
    load_req = 1'b0;
    wait_done(cyc);
    check("t3_w1", wlog_data[1], 32'h0000_BBAA);
    check("t3_count", word_count, 2);
    repeat (3) tick();

    // Back-to-back bytes: the fifth arrives during the WRITE cycle.
    stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h55};
    wlog_addr.delete(); wlog_data.delete();
    model_build(1'b1);
    load_req = 1'b1;
    tick();
    send(0);
    load_req = 1'b0;
    wait_done(cyc);
    check("t4_w0", wlog_data[0], 32'h0403_0201);
    check("t4_w1", wlog_data[1], 32'h0000_0055);
    repeat (3) tick();

    // 20 bytes: default instance writes 5 words, DEPTH=4 instance stops at 4.
    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(8'(8'h10 + i));
    w4_addr.delete(); w4_data.delete(); d4_done_n = 0;
    model_build(1'b1);
    load_req = 1'b1;
    tick();
    send(1);
    repeat (2) tick();
    check("ovf_hold4_low", cpu_hold4, 1'b0);
    check("ovf_done4_once", d4_done_n, 1);
    check("ovf_nwr4", w4_data.size(), 4);
    check("ovf_addr4_3", w4_addr[3], 14'd3);
    check("ovf_w4_0", w4_data[0], 32'h1312_1110);
    check("ovf_w4_3", w4_data[3], 32'h1F1E_1D1C);
    check("ovf_count4", word_count4, 4);
    load_req = 1'b0;
    wait_done(cyc);
    check("ovf_count", word_count, 5);
    repeat (3) tick();
    check("ovf_no_rearm4", w4_data.size(), 4);

    // Reset in the middle of a load: two words written plus two pending bytes.
    stim = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
    wlog_addr.delete(); wlog_data.delete();
    model_build(1'b0);
    load_req = 1'b1;
    tick();
    send(1);
    tick();
    check("mid_hold_before", cpu_hold, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_hold", cpu_hold, 1'b0);
    check("mid_we", mem_we, 1'b0);
    check("mid_count", word_count, 0);
    check("mid_all_written", exp_q.size(), 0);
    check("mid_nwr", wlog_data.size(), 2);
    load_req = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (10) tick();
    check("mid_no_more_wr", wlog_data.size(), 2);
    check("mid_hold_after", cpu_hold, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
